// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt entry and mret sequencer: picks the event at commit,
// stalls the front end, drains memory traffic, pulses the CSR update, then redirects.
module trap_ctrl #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_commit_valid,
  input  logic [ADDR_W-1:0] i_commit_pc,
  input  logic [ADDR_W-1:0] i_commit_nxt_pc,
  input  logic              i_inst_ecall,
  input  logic              i_inst_ebreak,
  input  logic              i_inst_mret,
  input  logic              i_mstatus_mie,
  input  logic              i_mie_mtie,
  input  logic              i_clint_mtip,
  input  logic [XLEN-1:0]   i_mtvec,
  input  logic [ADDR_W-1:0] i_mepc,
  input  logic              i_mem_busy,
  output logic              o_stall,
  output logic              o_trap_enter,
  output logic              o_trap_mret,
  output logic [ADDR_W-1:0] o_trap_epc,
  output logic [XLEN-1:0]   o_trap_cause,
  output logic              o_redirect_valid,
  output logic [ADDR_W-1:0] o_redirect_pc,
  output logic [31:0]       o_trap_cnt
);

  localparam logic [XLEN-1:0] EcallCause  = XLEN'(11);
  localparam logic [XLEN-1:0] EbreakCause = XLEN'(3);
  localparam logic [XLEN-1:0] IrqCause    = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {StIdle, StDrain, StEnter, StRet, StRedirect} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_epc, r_target;
  logic [XLEN-1:0]   r_cause;
  logic              r_kind_ret;
  logic [31:0]       r_trap_cnt;

  logic              w_irq, w_accept;
  logic [ADDR_W-1:0] w_epc_acc, w_base, w_trap_target;
  logic [XLEN-1:0]   w_cause_acc;

  assign w_irq    = i_mstatus_mie & i_mie_mtie & i_clint_mtip;
  assign w_accept = (r_state == StIdle) & i_commit_valid &
                    (i_inst_mret | i_inst_ecall | i_inst_ebreak | w_irq);

  always_comb begin
    w_cause_acc = IrqCause;
    w_epc_acc   = i_commit_nxt_pc;
    if (i_inst_ecall) begin
      w_cause_acc = EcallCause;
      w_epc_acc   = i_commit_pc;
    end else if (i_inst_ebreak) begin
      w_cause_acc = EbreakCause;
      w_epc_acc   = i_commit_pc;
    end
  end

  // Vectored mode only applies to interrupts; exceptions always go to the base.
  always_comb begin
    w_base        = {i_mtvec[ADDR_W-1:2], 2'b00};
    w_trap_target = w_base;
    if ((i_mtvec[1:0] == 2'b01) && r_cause[XLEN-1]) begin
      w_trap_target = w_base + ADDR_W'({r_cause[XLEN-2:0], 2'b00});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (i_mem_busy)       w_state_nxt = StDrain;
          else if (i_inst_mret) w_state_nxt = StRet;
          else                  w_state_nxt = StEnter;
        end
      end
      StDrain: begin
        if (!i_mem_busy) w_state_nxt = r_kind_ret ? StRet : StEnter;
      end
      StEnter:    w_state_nxt = StRedirect;
      StRet:      w_state_nxt = StRedirect;
      StRedirect: w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_epc      <= '0;
      r_cause    <= '0;
      r_target   <= '0;
      r_kind_ret <= 1'b0;
      r_trap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_kind_ret <= i_inst_mret;
        if (i_inst_mret) begin
          r_target <= i_mepc;
        end else begin
          r_epc   <= w_epc_acc;
          r_cause <= w_cause_acc;
        end
      end
      if (r_state == StEnter) begin
        r_target   <= w_trap_target;
        r_trap_cnt <= r_trap_cnt + 32'd1;
      end
    end
  end

  assign o_stall          = (r_state != StIdle);
  assign o_trap_enter     = (r_state == StEnter);
  assign o_trap_mret      = (r_state == StRet);
  assign o_redirect_valid = (r_state == StRedirect);
  assign o_redirect_pc    = r_target;
  assign o_trap_epc       = r_epc;
  assign o_trap_cause     = r_cause;
  assign o_trap_cnt       = r_trap_cnt;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: ecall, ebreak, vectored irq, priority, drained mret, reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc, commit_nxt_pc;
  logic        inst_ecall, inst_ebreak, inst_mret;
  logic        mstatus_mie, mie_mtie, clint_mtip;
  logic [63:0] mtvec, mepc;
  logic        mem_busy;
  logic        stall, trap_enter, trap_mret, redirect_valid;
  logic [63:0] trap_epc, trap_cause, redirect_pc;
  logic [31:0] trap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] IrqCause = 64'h8000_0000_0000_0007;

  trap_ctrl #(.XLEN(64), .ADDR_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_commit_valid   (commit_valid),
    .i_commit_pc      (commit_pc),
    .i_commit_nxt_pc  (commit_nxt_pc),
    .i_inst_ecall     (inst_ecall),
    .i_inst_ebreak    (inst_ebreak),
    .i_inst_mret      (inst_mret),
    .i_mstatus_mie    (mstatus_mie),
    .i_mie_mtie       (mie_mtie),
    .i_clint_mtip     (clint_mtip),
    .i_mtvec          (mtvec),
    .i_mepc           (mepc),
    .i_mem_busy       (mem_busy),
    .o_stall          (stall),
    .o_trap_enter     (trap_enter),
    .o_trap_mret      (trap_mret),
    .o_trap_epc       (trap_epc),
    .o_trap_cause     (trap_cause),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_trap_cnt       (trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc, input logic ec, input logic eb, input logic mr);
    commit_valid  = 1'b1;
    commit_pc     = pc;
    commit_nxt_pc = pc + 64'd4;
    inst_ecall    = ec;
    inst_ebreak   = eb;
    inst_mret     = mr;
    tick();
    commit_valid  = 1'b0;
    inst_ecall    = 1'b0;
    inst_ebreak   = 1'b0;
    inst_mret     = 1'b0;
  endtask

  // Checks ENTER then REDIRECT then IDLE of a trap whose accept edge just passed.
  task automatic expect_trap(input string tag, input logic [63:0] epc, input logic [63:0] cause,
                             input logic [63:0] target, input logic [31:0] cnt_after);
    check({tag, "_enter"}, 64'(trap_enter), 64'd1);
    check({tag, "_epc"}, trap_epc, epc);
    check({tag, "_cause"}, trap_cause, cause);
    tick();
    check({tag, "_redir_v"}, 64'(redirect_valid), 64'd1);
    check({tag, "_redir_pc"}, redirect_pc, target);
    check({tag, "_enter_low"}, 64'(trap_enter), 64'd0);
    tick();
    check({tag, "_stall_low"}, 64'(stall), 64'd0);
    check({tag, "_cnt"}, 64'(trap_cnt), 64'(cnt_after));
  endtask

  initial begin
    rst = 1'b1;
    commit_valid = 1'b0; commit_pc = '0; commit_nxt_pc = '0;
    inst_ecall = 1'b0; inst_ebreak = 1'b0; inst_mret = 1'b0;
    mstatus_mie = 1'b0; mie_mtie = 1'b0; clint_mtip = 1'b0;
    mtvec = '0; mepc = '0; mem_busy = 1'b0;
    tick();
    tick();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_enter", 64'(trap_enter), 64'd0);
    check("rst_mret", 64'(trap_mret), 64'd0);
    check("rst_redir_v", 64'(redirect_valid), 64'd0);
    check("rst_redir_pc", redirect_pc, 64'd0);
    check("rst_epc", trap_epc, 64'd0);
    check("rst_cause", trap_cause, 64'd0);
    check("rst_cnt", 64'(trap_cnt), 64'd0);
    rst = 1'b0;

    // ecall, direct mode
    mtvec = 64'h8000_0520;
    commit(64'h8000_0100, 1'b1, 1'b0, 1'b0);
    check("ecall_stall", 64'(stall), 64'd1);
    check("ecall_cnt_pre", 64'(trap_cnt), 64'd0);
    expect_trap("ecall", 64'h8000_0100, 64'd11, 64'h8000_0520, 32'd1);

    // timer interrupt, vectored mode
    mstatus_mie = 1'b1; mie_mtie = 1'b1; clint_mtip = 1'b1;
    mtvec = 64'h8000_0401;
    commit(64'h8000_0200, 1'b0, 1'b0, 1'b0);
    expect_trap("irq", 64'h8000_0204, IrqCause, 64'h8000_041C, 32'd2);

    // ecall beats pending irq; exceptions ignore vectored mode
    commit(64'h8000_0600, 1'b1, 1'b0, 1'b0);
    expect_trap("prio_ecall", 64'h8000_0600, 64'd11, 64'h8000_0400, 32'd3);
    commit(64'h8000_0700, 1'b0, 1'b0, 1'b0);
    expect_trap("prio_irq", 64'h8000_0704, IrqCause, 64'h8000_041C, 32'd4);

    // ebreak; mtvec changed after accept is sampled in ENTER
    mstatus_mie = 1'b0;
    mtvec = 64'h8000_0520;
    commit(64'h8000_0800, 1'b0, 1'b1, 1'b0);
    mtvec = 64'h8000_0900;
    expect_trap("ebreak", 64'h8000_0800, 64'd3, 64'h8000_0900, 32'd5);

    // mret with three cycles of memory drain; mepc change after accept ignored
    mepc = 64'h8000_0300;
    mem_busy = 1'b1;
    commit(64'h8000_0a00, 1'b0, 1'b0, 1'b1);
    mepc = 64'hdead_0000;
    check("mret_drain1_stall", 64'(stall), 64'd1);
    check("mret_drain1_mret", 64'(trap_mret), 64'd0);
    tick();
    check("mret_drain2_mret", 64'(trap_mret), 64'd0);
    tick();
    mem_busy = 1'b0;
    check("mret_drain3_mret", 64'(trap_mret), 64'd0);
    check("mret_drain3_redir", 64'(redirect_valid), 64'd0);
    tick();
    check("mret_pulse", 64'(trap_mret), 64'd1);
    check("mret_no_enter", 64'(trap_enter), 64'd0);
    tick();
    check("mret_pulse_low", 64'(trap_mret), 64'd0);
    check("mret_redir_v", 64'(redirect_valid), 64'd1);
    check("mret_redir_pc", redirect_pc, 64'h8000_0300);
    tick();
    check("mret_stall_low", 64'(stall), 64'd0);
    check("mret_cnt", 64'(trap_cnt), 64'd5);

    // masked irq, then unmasked irq without a commit: no action
    mstatus_mie = 1'b0; mie_mtie = 1'b1; clint_mtip = 1'b1;
    commit(64'h8000_0b00, 1'b0, 1'b0, 1'b0);
    check("masked_stall", 64'(stall), 64'd0);
    mstatus_mie = 1'b1;
    tick();
    check("nocommit_stall", 64'(stall), 64'd0);
    check("nocommit_enter", 64'(trap_enter), 64'd0);
    check("nocommit_cnt", 64'(trap_cnt), 64'd5);
    mstatus_mie = 1'b0;

    // reset while draining
    mem_busy = 1'b1;
    commit(64'h8000_0c00, 1'b1, 1'b0, 1'b0);
    check("rstdrain_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_busy = 1'b0;
    check("rstdrain_stall_low", 64'(stall), 64'd0);
    check("rstdrain_cnt", 64'(trap_cnt), 64'd0);
    tick();
    check("rstdrain_enter", 64'(trap_enter), 64'd0);
    check("rstdrain_mret", 64'(trap_mret), 64'd0);
    check("rstdrain_redir", 64'(redirect_valid), 64'd0);
    check("rstdrain_idle", 64'(stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
